gt_refclk_ctrl: RTL and testbench

GT_REFCLK_CTRL -- requirements
Module: gt_refclk_ctrl

---
 rtl/gt_refclk_ctrl_pkg.sv | 18 +
 rtl/gt_refclk_ch_fsm.sv | 155 +++++++++++++++
 rtl/gt_refclk_ctrl.sv | 67 ++++++
 tb/tb_gt_refclk_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gt_refclk_ctrl_pkg.sv
// Shared types and parameter defaults for the GT reference-clock controller.
package gt_refclk_ctrl_pkg;

  // Per-channel controller state; 2 bits so it packs into the debug bus.
  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_CLEAR   = 2'd1,
    ST_ENABLED = 2'd2,
    ST_LOST    = 2'd3
  } ch_state_t;

  localparam int unsigned DEF_NUM_CH        = 4;
  localparam int unsigned DEF_STABLE_CYCLES = 1024;
  localparam int unsigned DEF_CLR_CYCLES    = 8;
  localparam int unsigned DEF_WINDOW_CYCLES = 4096;
  localparam int unsigned DEF_MIN_TOGGLES   = 16;

endpackage

// File: rtl/gt_refclk_ch_fsm.sv
// One reference-clock channel: input synchronisers, power-good qualification,
// BUFG_GT CE/CLR sequencing, heartbeat activity check and loss statistics.
// The FSM state is exported on 'state' for debug visibility.
module gt_refclk_ch_fsm
  import gt_refclk_ctrl_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned CLR_CYCLES    = DEF_CLR_CYCLES,
  parameter int unsigned MIN_TOGGLES   = DEF_MIN_TOGGLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pg_async,
  input  logic       tgl_async,
  input  logic       eval_pt,
  input  logic       clr_stat,
  output logic       buf_ce,
  output logic       buf_clr,
  output logic       ref_ok,
  output logic       lost_sticky,
  output logic [7:0] lost_cnt,
  output ch_state_t  state
);

  localparam int unsigned STB_W = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned CLR_W = $clog2(CLR_CYCLES + 1);
  localparam int unsigned EDG_W = $clog2(MIN_TOGGLES + 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);
  localparam logic [EDG_W-1:0] EDG_SAT  = EDG_W'(MIN_TOGGLES);

  logic             pg_s1, pg_sync;
  logic             tgl_s1, tgl_s2, tgl_d;
  logic             tgl_edge;
  logic [STB_W-1:0] stb_cnt;
  logic [CLR_W-1:0] clr_cnt;
  logic [EDG_W-1:0] edge_cnt;
  logic             primed;
  logic             pass;
  logic             lost_evt;

  // Two-flop synchronisers plus one history flop for heartbeat edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pg_s1   <= 1'b0;
      pg_sync <= 1'b0;
      tgl_s1  <= 1'b0;
      tgl_s2  <= 1'b0;
      tgl_d   <= 1'b0;
    end else begin
      pg_s1   <= pg_async;
      pg_sync <= pg_s1;
      tgl_s1  <= tgl_async;
      tgl_s2  <= tgl_s1;
      tgl_d   <= tgl_s2;
    end
  end

  assign tgl_edge = tgl_s2 ^ tgl_d;
  assign pass     = (edge_cnt >= EDG_SAT);
  // A loss is only counted on a primed evaluation while power is still good.
  assign lost_evt = (state == ST_ENABLED) && pg_sync && eval_pt && primed && !pass;

  // Outputs decode straight from the state flop, so they carry no input path.
  assign buf_ce  = (state != ST_OFF);
  assign buf_clr = (state == ST_OFF) || (state == ST_CLEAR);

  // Channel FSM; a power-good drop outranks every other transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_OFF;
      stb_cnt <= '0;
      clr_cnt <= '0;
      primed  <= 1'b0;
      ref_ok  <= 1'b0;
    end else if (state == ST_OFF) begin
      ref_ok  <= 1'b0;
      primed  <= 1'b0;
      clr_cnt <= '0;
      if (!pg_sync) begin
        stb_cnt <= '0;
      end else if (stb_cnt == STB_LAST) begin
        stb_cnt <= '0;
        state   <= ST_CLEAR;
      end else begin
        stb_cnt <= stb_cnt + 1'b1;
      end
    end else if (!pg_sync) begin
      state   <= ST_OFF;
      stb_cnt <= '0;
      clr_cnt <= '0;
      primed  <= 1'b0;
      ref_ok  <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr_cnt == CLR_LAST) begin
            clr_cnt <= '0;
            primed  <= 1'b0;
            state   <= ST_ENABLED;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        ST_ENABLED: begin
          if (eval_pt) begin
            if (!primed) begin
              // First window after enabling is partial; only arm the check.
              primed <= 1'b1;
            end else if (!pass) begin
              state  <= ST_LOST;
              ref_ok <= 1'b0;
            end else begin
              ref_ok <= 1'b1;
            end
          end
        end
        ST_LOST: begin
          if (eval_pt && pass) begin
            state  <= ST_ENABLED;
            ref_ok <= 1'b1;
          end
        end
        default: state <= ST_OFF;
      endcase
    end
  end

  // Heartbeat edge counter, saturating, restarted each window and while not running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
    end else if ((state == ST_OFF) || (state == ST_CLEAR) || eval_pt) begin
      edge_cnt <= '0;
    end else if (tgl_edge && (edge_cnt != EDG_SAT)) begin
      edge_cnt <= edge_cnt + 1'b1;
    end
  end

  // Loss statistics; a loss in the same cycle as a clear is kept as the first loss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lost_sticky <= 1'b0;
      lost_cnt    <= 8'd0;
    end else if (lost_evt) begin
      lost_sticky <= 1'b1;
      if (clr_stat)               lost_cnt <= 8'd1;
      else if (lost_cnt != 8'hFF) lost_cnt <= lost_cnt + 8'd1;
    end else if (clr_stat) begin
      lost_sticky <= 1'b0;
      lost_cnt    <= 8'd0;
    end
  end

endmodule

// File: rtl/gt_refclk_ctrl.sv
// GT reference-clock controller: one shared activity window and NUM_CH
// independent channel controllers. ch_state exposes every channel FSM state.
module gt_refclk_ctrl
  import gt_refclk_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CH        = DEF_NUM_CH,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned CLR_CYCLES    = DEF_CLR_CYCLES,
  parameter int unsigned WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int unsigned MIN_TOGGLES   = DEF_MIN_TOGGLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     gt_powergood,
  input  logic [NUM_CH-1:0]     refclk_tgl,
  input  logic                  clr_stat,
  output logic [NUM_CH-1:0]     buf_ce,
  output logic [NUM_CH-1:0]     buf_clr,
  output logic [NUM_CH-1:0]     ref_ok,
  output logic                  all_ok,
  output logic [NUM_CH-1:0]     lost_sticky,
  output logic [8*NUM_CH-1:0]   lost_cnt,
  output logic [2*NUM_CH-1:0]   ch_state
);

  localparam int unsigned WIN_W = $clog2(WINDOW_CYCLES + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

  logic [WIN_W-1:0] win_cnt;
  logic             eval_pt;

  // Free-running measurement window shared by all channels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   win_cnt <= '0;
    else if (win_cnt == WIN_LAST) win_cnt <= '0;
    else                          win_cnt <= win_cnt + 1'b1;
  end

  assign eval_pt = (win_cnt == WIN_LAST);
  assign all_ok  = &ref_ok;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_state_t st;

    gt_refclk_ch_fsm #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .CLR_CYCLES    (CLR_CYCLES),
      .MIN_TOGGLES   (MIN_TOGGLES)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .pg_async    (gt_powergood[i]),
      .tgl_async   (refclk_tgl[i]),
      .eval_pt     (eval_pt),
      .clr_stat    (clr_stat),
      .buf_ce      (buf_ce[i]),
      .buf_clr     (buf_clr[i]),
      .ref_ok      (ref_ok[i]),
      .lost_sticky (lost_sticky[i]),
      .lost_cnt    (lost_cnt[8*i +: 8]),
      .state       (st)
    );

    assign ch_state[2*i +: 2] = st;
  end

endmodule

// File: tb/tb_gt_refclk_ctrl.sv
// Directed bench for gt_refclk_ctrl (2 channels, short qualification and
// window). The driver pushes expected values into exp_q; the monitor pops and
// compares them against the DUT half a cycle away from the active edge.
`timescale 1ns/1ps
module tb_gt_refclk_ctrl;
  import gt_refclk_ctrl_pkg::*;

  localparam int NUM_CH        = 2;
  localparam int STABLE_CYCLES = 16;
  localparam int CLR_CYCLES    = 4;
  localparam int WINDOW_CYCLES = 64;
  localparam int MIN_TOGGLES   = 8;
  localparam int W             = 48;

  localparam logic [7:0] S_CE = 8'd0, S_CLR = 8'd1, S_OK = 8'd2, S_ALL = 8'd3;
  localparam logic [7:0] S_STK = 8'd4, S_CNT = 8'd5, S_ST = 8'd6, S_MEAS = 8'd7;
  localparam logic [7:0] ALL = 8'hFF;

  // ---------------- clock / reset ----------------
  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NUM_CH-1:0]     gt_powergood = '0;
  logic [NUM_CH-1:0]     refclk_tgl = '0;
  logic                  clr_stat = 1'b0;
  logic [NUM_CH-1:0]     buf_ce, buf_clr, ref_ok, lost_sticky;
  logic                  all_ok;
  logic [8*NUM_CH-1:0]   lost_cnt;
  logic [2*NUM_CH-1:0]   ch_state;

  initial forever #5 clk = ~clk;

  gt_refclk_ctrl #(
    .NUM_CH(NUM_CH), .STABLE_CYCLES(STABLE_CYCLES), .CLR_CYCLES(CLR_CYCLES),
    .WINDOW_CYCLES(WINDOW_CYCLES), .MIN_TOGGLES(MIN_TOGGLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .gt_powergood(gt_powergood), .refclk_tgl(refclk_tgl),
    .clr_stat(clr_stat), .buf_ce(buf_ce), .buf_clr(buf_clr), .ref_ok(ref_ok),
    .all_ok(all_ok), .lost_sticky(lost_sticky), .lost_cnt(lost_cnt), .ch_state(ch_state)
  );

  // Bench copy of the window position: after every posedge where pc%64==0 an
  // evaluation point has just occurred.
  int unsigned pc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= 0;
    else        pc <= pc + 1;
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_cmp = 0;
  int           n_fail = 0;
  logic [31:0]  meas [4];

  function automatic logic [31:0] pick(input logic [7:0] sel, input logic [7:0] idx);
    logic [31:0] v;
    v = '0;
    case (sel)
      S_CE:    v = 32'(buf_ce);
      S_CLR:   v = 32'(buf_clr);
      S_OK:    v = 32'(ref_ok);
      S_ALL:   v = 32'(all_ok);
      S_STK:   v = 32'(lost_sticky);
      S_CNT:   v = 32'(lost_cnt);
      S_ST:    v = 32'(ch_state);
      default: return meas[idx[1:0]];
    endcase
    if (idx != ALL) v = {31'd0, v[idx[4:0]]};
    return v;
  endfunction

  task automatic expect_val(input string name, input logic [7:0] sel,
                            input logic [7:0] idx, input logic [31:0] val);
    exp_q.push_back({sel, idx, val});
    name_q.push_back(name);
  endtask

  task automatic check_now(input string name, input logic [31:0] act,
                           input logic [31:0] val);
    n_cmp++;
    if (act !== val) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, val);
    end
  endtask

  // Monitor: drains every pending expectation 1 ns after each falling edge.
  initial begin
    logic [W-1:0] e;
    logic [31:0]  act;
    string        nm;
    forever begin
      @(negedge clk);
      #1;
      while (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = pick(e[47:40], e[39:32]);
        n_cmp++;
        if (act !== e[31:0]) begin
          n_fail++;
          $display("FAIL %s: got %0h expected %0h", nm, act, e[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [NUM_CH-1:0] hb_en = '0;
  logic [NUM_CH-1:0] hb_ph = '0;

  // Heartbeat generator: each enabled channel toggles every 2 cycles.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < NUM_CH; i++) begin
      if (hb_en[i]) begin
        if (hb_ph[i]) refclk_tgl[i] = ~refclk_tgl[i];
        hb_ph[i] = ~hb_ph[i];
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts falling edges until the selected bit equals val; budget+1 on timeout.
  task automatic wait_bit(input logic [7:0] sel, input int ch, input logic val,
                          input int budget, output int cyc);
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (pick(sel, 8'(ch)) == {31'd0, val}) break;
      if (cyc > budget) break;
    end
  endtask

  task automatic align_eval();
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (((pc % WINDOW_CYCLES) != 0) && (c < 2 * WINDOW_CYCLES));
  endtask

  task automatic wait_window_pos(input int unsigned pos);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (((pc % WINDOW_CYCLES) != pos) && (c < 2 * WINDOW_CYCLES));
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int cyc, ce_at, clr_at, evals;

    // Reset values
    @(negedge clk);
    expect_val("rst_ce",  S_CE,  ALL, 32'h0);
    expect_val("rst_clr", S_CLR, ALL, 32'h3);
    expect_val("rst_ok",  S_OK,  ALL, 32'h0);
    expect_val("rst_all", S_ALL, ALL, 32'h0);
    expect_val("rst_stk", S_STK, ALL, 32'h0);
    expect_val("rst_cnt", S_CNT, ALL, 32'h0);
    expect_val("rst_st",  S_ST,  ALL, 32'h0);
    n_cmp++;
    if (buf_ce !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_ce_now: got %0h expected 0", buf_ce);
    end
    n_cmp++;
    if (buf_clr !== 2'b11) begin
      n_fail++;
      $display("FAIL rst_clr_now: got %0h expected 3", buf_clr);
    end
    n_cmp++;
    if (lost_cnt !== 16'h0000) begin
      n_fail++;
      $display("FAIL rst_cnt_now: got %0h expected 0", lost_cnt);
    end
    check_now("rst_st_now", 32'(ch_state), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    hb_en = 2'b11;

    // Channel 0 qualification: CLEAR after 2+16, CLR falls after 2+16+4
    gt_powergood[0] = 1'b1;
    ce_at = 0; clr_at = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (ce_at == 0 && buf_ce[0]) ce_at = c;
      if (clr_at == 0 && !buf_clr[0]) begin clr_at = c; break; end
    end
    meas[0] = ce_at; meas[1] = clr_at;
    expect_val("q0_ce_lat",  S_MEAS, 8'd0, 32'd18);
    expect_val("q0_clr_lat", S_MEAS, 8'd1, 32'd22);
    expect_val("q0_ce_on",   S_CE,   8'd0, 32'h1);
    expect_val("q0_state",   S_ST,   ALL,  32'h2);

    // Channel 1: glitch in power-good restarts qualification
    gt_powergood[1] = 1'b1;
    tick(10);
    gt_powergood[1] = 1'b0;
    tick(1);
    gt_powergood[1] = 1'b1;
    wait_bit(S_CE, 1, 1'b1, 60, cyc);
    meas[2] = cyc;
    expect_val("q1_restart_lat", S_MEAS, 8'd2, 32'd18);
    @(negedge clk);
    wait_bit(S_CLR, 1, 1'b0, 20, cyc);
    meas[3] = cyc + 1;
    expect_val("q1_clear_len", S_MEAS, 8'd3, 32'd4);
    expect_val("q1_ok_early",  S_OK,   8'd1, 32'h0);

    // ref_ok rises after the second evaluation point following ENABLED
    @(negedge clk);
    evals = 0;
    for (int c = 0; c < 4 * WINDOW_CYCLES; c++) begin
      if ((pc % WINDOW_CYCLES) == 0) evals++;
      if (ref_ok[1]) break;
      @(negedge clk);
    end
    meas[0] = evals;
    expect_val("ok1_evals", S_MEAS, 8'd0, 32'd2);
    expect_val("ok1_up",    S_OK,   8'd1, 32'h1);
    wait_bit(S_ALL, 0, 1'b1, 300, cyc);
    expect_val("all_ok_up", S_ALL, ALL, 32'h1);
    expect_val("ok_both",   S_OK,  ALL, 32'h3);

    // Heartbeat stops on channel 0 -> LOST at next evaluation
    align_eval();
    hb_en[0] = 1'b0;
    wait_bit(S_OK, 0, 1'b0, 200, cyc);
    meas[1] = cyc;
    expect_val("loss_lat",   S_MEAS, 8'd1, 32'd64);
    expect_val("loss_stk",   S_STK,  ALL,  32'h1);
    expect_val("loss_cnt",   S_CNT,  ALL,  32'h0001);
    expect_val("loss_ok",    S_OK,   ALL,  32'h2);
    expect_val("loss_state", S_ST,   ALL,  32'hB);
    hb_en[0] = 1'b1;
    wait_bit(S_OK, 0, 1'b1, 200, cyc);
    meas[2] = cyc;
    expect_val("recover_lat", S_MEAS, 8'd2, 32'd64);
    expect_val("recover_cnt", S_CNT,  ALL,  32'h0001);
    expect_val("recover_stk", S_STK,  ALL,  32'h1);
    expect_val("recover_all", S_ALL,  ALL,  32'h1);

    // Power-good drop while LOST -> OFF
    hb_en[0] = 1'b0;
    wait_bit(S_OK, 0, 1'b0, 200, cyc);
    gt_powergood[0] = 1'b0;
    wait_bit(S_CE, 0, 1'b0, 20, cyc);
    meas[3] = cyc;
    expect_val("pgdrop_lat",   S_MEAS, 8'd3, 32'd3);
    expect_val("pgdrop_clr",   S_CLR,  8'd0, 32'h1);
    expect_val("pgdrop_state", S_ST,   ALL,  32'h8);
    expect_val("pgdrop_cnt",   S_CNT,  ALL,  32'h0002);
    expect_val("pgdrop_ok",    S_OK,   ALL,  32'h2);

    // Re-enable and induce many losses to reach saturation
    gt_powergood[0] = 1'b1;
    hb_en[0] = 1'b1;
    wait_bit(S_OK, 0, 1'b1, 300, cyc);
    expect_val("reen_ok", S_OK, 8'd0, 32'h1);
    for (int k = 0; k < 100; k++) begin
      hb_en[0] = 1'b0; tick(WINDOW_CYCLES);
      hb_en[0] = 1'b1; tick(WINDOW_CYCLES);
    end
    expect_val("cnt_102", S_CNT, ALL, 32'h0066);
    for (int k = 0; k < 160; k++) begin
      hb_en[0] = 1'b0; tick(WINDOW_CYCLES);
      hb_en[0] = 1'b1; tick(WINDOW_CYCLES);
    end
    expect_val("cnt_sat", S_CNT, ALL, 32'h00FF);
    expect_val("sat_stk", S_STK, ALL, 32'h1);
    expect_val("sat_ok",  S_OK,  ALL, 32'h3);

    // clr_stat clears statistics
    clr_stat = 1'b1;
    @(negedge clk);
    clr_stat = 1'b0;
    expect_val("clr_cnt", S_CNT, ALL, 32'h0);
    expect_val("clr_stk", S_STK, ALL, 32'h0);

    // clr_stat coinciding with a loss: the loss wins
    hb_en[0] = 1'b0;
    wait_window_pos(WINDOW_CYCLES - 1);
    clr_stat = 1'b1;
    @(negedge clk);
    clr_stat = 1'b0;
    expect_val("clrloss_stk", S_STK, ALL, 32'h1);
    expect_val("clrloss_cnt", S_CNT, ALL, 32'h0001);
    expect_val("clrloss_ok",  S_OK,  ALL, 32'h2);

    // Asynchronous reset mid-ENABLED on channel 1
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ref_ok !== 2'b00) begin
      n_fail++;
      $display("FAIL arst_ok_now: got %0h expected 0", ref_ok);
    end
    n_cmp++;
    if (lost_sticky !== 2'b00) begin
      n_fail++;
      $display("FAIL arst_stk_now: got %0h expected 0", lost_sticky);
    end
    check_now("arst_all_now", 32'(all_ok), 32'h0);
    expect_val("arst_ce",  S_CE,  ALL, 32'h0);
    expect_val("arst_clr", S_CLR, ALL, 32'h3);
    expect_val("arst_ok",  S_OK,  ALL, 32'h0);
    expect_val("arst_all", S_ALL, ALL, 32'h0);
    expect_val("arst_stk", S_STK, ALL, 32'h0);
    expect_val("arst_cnt", S_CNT, ALL, 32'h0);
    expect_val("arst_st",  S_ST,  ALL, 32'h0);
    tick(1);
    @(negedge clk);
    rst_n = 1'b1;
    wait_bit(S_CE, 0, 1'b1, 60, cyc);
    meas[0] = cyc;
    expect_val("rerun_lat", S_MEAS, 8'd0, 32'd18);
    expect_val("rerun_ce",  S_CE,   ALL,  32'h3);

    tick(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
